// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - tick-driven PWM generator with period/duty registers; PWM_SHADOW_EN enables double buffering
module pwm_generator #(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 div_clk,
    input  logic                 wr,
    input  logic [1:0]           addr,
    input  logic [PWM_WIDTH-1:0] wdata,
    output logic [PWM_WIDTH-1:0] rdata,
    output logic                 pwm_out,
    output logic                 period_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [PWM_WIDTH-1:0] cnt, cnt_n;
    logic [PWM_WIDTH-1:0] period_a, period_a_n;
    logic [PWM_WIDTH-1:0] duty_a, duty_a_n;
    logic                 enable, enable_n;
    logic                 polarity, polarity_n;
    logic                 div_q;
    logic                 tick;
    logic                 wrap;
    logic                 pe_n;
    logic                 pwm_n;
    logic                 wr_period, wr_duty, wr_ctrl;

`ifdef PWM_SHADOW_EN
    logic [PWM_WIDTH-1:0] period, period_n;
    logic [PWM_WIDTH-1:0] duty, duty_n;
`endif

    assign tick      = div_clk & ~div_q;
    assign wr_period = wr && (addr == 2'd0);
    assign wr_duty   = wr && (addr == 2'd1);
    assign wr_ctrl   = wr && (addr == 2'd2);
    // >= rather than == so a freshly written shorter period wraps on the next tick
    assign wrap      = (cnt >= period_a);

    always_comb begin
        enable_n   = wr_ctrl ? wdata[0] : enable;
        polarity_n = wr_ctrl ? wdata[1] : polarity;
`ifdef PWM_SHADOW_EN
        period_n   = wr_period ? wdata : period;
        duty_n     = wr_duty   ? wdata : duty;
        period_a_n = period_a;
        duty_a_n   = duty_a;
`else
        period_a_n = wr_period ? wdata : period_a;
        duty_a_n   = wr_duty   ? wdata : duty_a;
`endif
        state_n    = state;
        cnt_n      = cnt;
        pe_n       = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = RUN;
`ifdef PWM_SHADOW_EN
                    period_a_n = period_n;
                    duty_a_n   = duty_n;
`endif
                end
            end
            RUN, DRAIN: begin
                state_n = enable ? RUN : DRAIN;
                if (tick) begin
                    if (wrap) begin
                        cnt_n = '0;
                        pe_n  = 1'b1;
                        if (state == DRAIN) begin
                            state_n = IDLE;
                        end else begin
`ifdef PWM_SHADOW_EN
                            // pending values include a write landing this very cycle
                            period_a_n = period_n;
                            duty_a_n   = duty_n;
`endif
                        end
                    end else begin
                        cnt_n = cnt + PWM_WIDTH'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        pwm_n = (state_n == IDLE) ? polarity_n : ((cnt_n < duty_a_n) ^ polarity_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            div_q      <= 1'b0;
            period_a   <= '1;
            duty_a     <= '0;
            enable     <= 1'b0;
            polarity   <= 1'b0;
            pwm_out    <= 1'b0;
            period_end <= 1'b0;
`ifdef PWM_SHADOW_EN
            period     <= '1;
            duty       <= '0;
`endif
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            div_q      <= div_clk;
            period_a   <= period_a_n;
            duty_a     <= duty_a_n;
            enable     <= enable_n;
            polarity   <= polarity_n;
            pwm_out    <= pwm_n;
            period_end <= pe_n;
`ifdef PWM_SHADOW_EN
            period     <= period_n;
            duty       <= duty_n;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
`ifdef PWM_SHADOW_EN
            2'd0: rdata = period;
            2'd1: rdata = duty;
`else
            2'd0: rdata = period_a;
            2'd1: rdata = duty_a;
`endif
            2'd2: rdata[3:0] = {state, polarity, enable};
            default: rdata = cnt;
        endcase
    end

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - self-checking bench for pwm_generator (default build or PWM_SHADOW_EN)
module tb_pwm_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       div_clk = 1'b0;
    logic       wr = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [7:0] wdata = 8'd0;
    logic [7:0] rdata;
    logic       pwm_out;
    logic       period_end;

    int n_checks = 0;
    int n_errors = 0;

    pwm_generator #(.PWM_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_clk    (div_clk),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .pwm_out    (pwm_out),
        .period_end (period_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] period;
        logic [7:0] duty;
        logic       pol;
        logic [8:0] pwm_exp;   // bit i: pwm_out after i ticks
        logic [8:0] pe_exp;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; div_clk = 1'b0; wr = 1'b0; addr = 2'd0; wdata = 8'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic write(input logic [1:0] a, input logic [7:0] d);
        wr = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_tick(input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        div_clk = 1'b1; wr = w; addr = a; wdata = d;
        @(negedge clk);
        div_clk = 1'b0; wr = 1'b0;
    endtask

    task automatic tick();
        do_tick(1'b0, 2'd0, 8'd0);
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        addr = a;
        #1;
        v = rdata;
    endtask

    task automatic start(input logic [7:0] p, input logic [7:0] d, input logic [7:0] ctrl);
        reset_dut();
        write(2'd0, p);
        write(2'd1, d);
        write(2'd2, ctrl);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] v;
        int highs, pes;

        vecs[0] = '{"p3d2",   8'd3, 8'd2, 1'b0, 9'b100110011, 9'b100010000};
        vecs[1] = '{"p3d0",   8'd3, 8'd0, 1'b0, 9'b000000000, 9'b100010000};
        vecs[2] = '{"p3d4",   8'd3, 8'd4, 1'b0, 9'b111111111, 9'b100010000};
        vecs[3] = '{"p3d1n",  8'd3, 8'd1, 1'b1, 9'b011101110, 9'b100010000};
        vecs[4] = '{"p0d1",   8'd0, 8'd1, 1'b0, 9'b111111111, 9'b111111110};

        // reset state
        reset_dut();
        check("rst_pwm", pwm_out, 0);
        check("rst_pe", period_end, 0);
        rd(2'd0, v); check("rst_period", v, 8'hff);
        rd(2'd1, v); check("rst_duty", v, 8'h00);
        rd(2'd2, v); check("rst_ctrl", v, 8'h00);
        rd(2'd3, v); check("rst_cnt", v, 8'h00);

        foreach (vecs[k]) begin
            start(vecs[k].period, vecs[k].duty, {6'd0, vecs[k].pol, 1'b1});
            for (int i = 0; i < 9; i++) begin
                if (i > 0) tick();
                check($sformatf("%s_pwm%0d", vecs[k].name, i), pwm_out, vecs[k].pwm_exp[i]);
                check($sformatf("%s_pe%0d", vecs[k].name, i), period_end, vecs[k].pe_exp[i]);
            end
        end

        // full-range period: 255 of every 256 ticks high
        start(8'd255, 8'd255, 8'd1);
        highs = 0; pes = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            highs += int'(pwm_out);
            pes   += int'(period_end);
        end
        check("p255_highs", highs, 510);
        check("p255_wraps", pes, 2);

        // drain: disable at counter 1, finish the period, then idle
        start(8'd3, 8'd2, 8'd1);
        tick();
        write(2'd2, 8'd0);
        @(negedge clk);
        rd(2'd2, v); check("drain_state", v, 8'h08);
        tick(); check("drain_pwm2", pwm_out, 0);
        tick(); check("drain_pwm3", pwm_out, 0);
        rd(2'd3, v); check("drain_cnt3", v, 8'd3);
        tick();
        check("drain_end_pe", period_end, 1);
        check("drain_end_pwm", pwm_out, 0);
        rd(2'd2, v); check("drain_idle", v, 8'h00);
        rd(2'd3, v); check("drain_cnt0", v, 8'd0);
        tick(); check("idle_hold_pwm", pwm_out, 0);
        rd(2'd3, v); check("idle_hold_cnt", v, 8'd0);

        // re-enable during drain keeps the waveform continuous
        start(8'd3, 8'd2, 8'd1);
        tick();
        write(2'd2, 8'd0);
        @(negedge clk);
        write(2'd2, 8'd1);
        @(negedge clk);
        rd(2'd2, v); check("reen_state", v, 8'h05);
        rd(2'd3, v); check("reen_cnt", v, 8'd1);
        tick(); check("reen_pwm2", pwm_out, 0);
        tick(); check("reen_pwm3", pwm_out, 0);
        tick();
        check("reen_pwm0", pwm_out, 1);
        check("reen_pe", period_end, 1);
        rd(2'd2, v); check("reen_run", v, 8'h05);

        // polarity in idle applies on the next edge
        reset_dut();
        write(2'd2, 8'd2);
        check("pol_idle_pwm", pwm_out, 1);
        rd(2'd2, v); check("pol_idle_ctrl", v, 8'h02);

        // asynchronous reset between clock edges
        start(8'd3, 8'd2, 8'd1);
        for (int i = 0; i < 5; i++) tick();
        check("arst_pre_pwm", pwm_out, 1);
        rd(2'd3, v); check("arst_pre_cnt", v, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pwm", pwm_out, 0);
        check("arst_pe", period_end, 0);
        rd(2'd2, v); check("arst_state", v, 8'h00);
        rd(2'd3, v); check("arst_cnt", v, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef PWM_SHADOW_EN
        // duty write mid-period waits for the wrap
        start(8'd3, 8'd2, 8'd1);
        tick();
        write(2'd1, 8'd1);
        check("sh_cur_pwm1", pwm_out, 1);
        rd(2'd1, v); check("sh_pending", v, 8'd1);
        tick(); check("sh_pwm2", pwm_out, 0);
        tick(); check("sh_pwm3", pwm_out, 0);
        tick();
        check("sh_pwm0", pwm_out, 1);
        check("sh_pe", period_end, 1);
        tick(); check("sh_new_pwm1", pwm_out, 0);
        tick();
        tick();
        // write landing on the wrap tick is used by that reload
        do_tick(1'b1, 2'd1, 8'd3);
        check("byp_pe", period_end, 1);
        check("byp_pwm0", pwm_out, 1);
        tick(); check("byp_pwm1", pwm_out, 1);
        tick(); check("byp_pwm2", pwm_out, 1);
`else
        // direct write of a period below the counter wraps on the next tick
        start(8'd3, 8'd2, 8'd1);
        tick(); tick(); tick();
        write(2'd0, 8'd1);
        check("dir_pwm3", pwm_out, 0);
        rd(2'd0, v); check("dir_period", v, 8'd1);
        tick();
        check("dir_wrap_pe", period_end, 1);
        check("dir_wrap_pwm", pwm_out, 1);
        rd(2'd3, v); check("dir_wrap_cnt", v, 8'd0);
        tick();
        check("dir_pwm1", pwm_out, 1);
        check("dir_pe1", period_end, 0);
        tick();
        check("dir_wrap2_pe", period_end, 1);
        write(2'd1, 8'd0);
        check("dir_duty0_pwm", pwm_out, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_generator.md
# pwm_generator

Tick-driven PWM generator that consumes the divided clock from the clock divider and produces one PWM output. It sits directly downstream of the divider: it counts rising edges of the divided clock in the `clk` domain and compares against a programmable period and duty. Period and duty are double-buffered through a register write port shared with the divider's `wr` strobe.

## Interface

Parameters:
- `PWM_WIDTH`, default 8: width of the period, duty and counter.

Ports:
- `clk` input, 1 bit: the single system clock. All logic is on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `div_clk` input, 1 bit: divided clock from the clock divider. Only its rising edges are used.
- `wr` input, 1 bit: write strobe, one `clk` cycle per write.
- `addr` input, 2 bits: register select.
  - 0 = period
  - 1 = duty
  - 2 = control: bit0 `enable`, bit1 `polarity`
  - 3 = read-only counter
- `wdata` input, `PWM_WIDTH` bits: write data.
- `rdata` output, `PWM_WIDTH` bits: combinational readback of `addr`.
  - 0: pending period
  - 1: pending duty
  - 2: `{0…, state[1:0], polarity, enable}`
  - 3: counter
- `pwm_out` output, 1 bit: registered PWM output.
- `period_end` output, 1 bit: registered one-cycle pulse on each counter wrap.

## Operation

Tick detection:
- `div_q <= div_clk`; `tick = div_clk & ~div_q`.
- The divider must run with div ≥ 1. When div = 0, `div_clk` equals `clk`, so no ticks are detected and the counter holds.

Registers:
- Pending `period` and `duty` are written by `wr` at addr 0 and 1.
- Active `period_a` and `duty_a` are used for the comparison.
- Writes to addr 3 are ignored.

State machine (`state` encoding):
- IDLE (0):
  - Counter is 0; `pwm_out = polarity`.
  - On `enable` written to 1: load `period_a`/`duty_a` from pending, counter = 0, go to RUN.
- RUN (1):
  - On tick: if counter == `period_a`, the counter wraps to 0, `period_end` pulses, and active registers reload from pending. Otherwise counter + 1.
  - On `enable` written to 0: go to DRAIN.
- DRAIN (2):
  - Counts exactly as in RUN.
  - At the wrap tick, go to IDLE instead of reloading.
  - On `enable` written to 1: go back to RUN with no disturbance to the counter.

Output:
- `pwm_out` is registered from the next-state counter: `(cnt_next < duty_a) ^ polarity`.
- `duty_a` = 0 gives a constant inactive level.
- `duty_a` > `period_a` gives a constant active level.
- `period_a` = 0 gives a one-tick cycle: `period_end` pulses every tick.

Arithmetic:
- Comparisons are unsigned, `PWM_WIDTH` bits.
- The counter never exceeds `period_a` (see Configuration for the non-shadowed case).

Simultaneous events:
- A `wr` in the same cycle as a wrap tick: the written value is used by that reload (bypass).
- A `polarity` write takes effect at the next `clk` edge in every state.

## Timing

Reset values (asynchronous):
- counter = 0, state = IDLE, `div_q` = 0
- pending period = all-ones, pending duty = 0
- `period_a` = all-ones, `duty_a` = 0
- `enable` = 0, `polarity` = 0
- `pwm_out` = 0, `period_end` = 0

Reset mid-operation: outputs go to their reset values immediately, without waiting for a `clk` edge.

Latency:
- `div_clk` rising edge sampled at edge N → counter, `pwm_out` and `period_end` update at edge N.
- `div_clk` must stay high at least 1 `clk` cycle.
- Write to `enable` at edge N → RUN and the first `pwm_out` value at edge N + 1.

## Configuration

- `PWM_SHADOW_EN` defined: period and duty writes land in the pending registers and reach the active registers only at a wrap or on IDLE→RUN, as described above.
- `PWM_SHADOW_EN` undefined: writes go straight into `period_a`/`duty_a` and the pending registers are removed; `rdata` at addr 0 and 1 returns the active values. If the counter is ≥ a newly written period, the next tick wraps the counter to 0 and pulses `period_end`.

## Test plan

- period=3, duty=2, enable=1, div=1 → `pwm_out` high 2 ticks, low 2 ticks, repeating; `period_end` once every 4 ticks.
- duty=0 → `pwm_out` constant 0. duty=4 with period=3 → constant 1. period=255, duty=255 → high 255 of every 256 ticks.
- Shadow: period=3, duty=2 running; write duty=1 at counter 1 → current cycle still high 2 ticks, next cycle high 1 tick. Write coinciding with the wrap tick → applied in the cycle that starts at that wrap.
- Write enable=0 at counter 1 → DRAIN, finishes through counter 3, then IDLE with `pwm_out`=`polarity`. Rewrite enable=1 during DRAIN → RUN, waveform continuous.
- polarity=1 in IDLE → `pwm_out`=1; running period=3, duty=1 → low 1 tick, high 3 ticks.
- Assert `rst_n`=0 mid-RUN between `clk` edges → `pwm_out`=0, `period_end`=0, readback state=IDLE, counter=0 immediately.
